// File: rtl/step_ramp_sched_pkg.sv
// Shared constants, state encodings and helpers for the stepper period ramp scheduler.
package step_ramp_pkg;

    localparam int PW = 17;

    localparam logic [PW-1:0] P_START = 17'd8333;
    localparam logic [PW-1:0] P_MIN   = 17'd1000;
    localparam logic [PW-1:0] DELTA   = 17'd64;

    localparam int DWELL = 500;
    localparam int DW_W  = 9;
    localparam logic [DW_W-1:0] DWELL_LAST = 9'(DWELL - 1);

    // Kept as plain vectors so older tools and waveform scripts see fixed encodings.
    typedef logic [2:0] state_t;
    localparam state_t S_IDLE  = 3'd0;
    localparam state_t S_RAMP  = 3'd1;
    localparam state_t S_HOLD  = 3'd2;
    localparam state_t S_DECEL = 3'd3;
    localparam state_t S_DWELL = 3'd4;

    typedef struct packed {
        logic [PW-1:0] period;
        logic          dir;
        logic          en;
    } target_t;

    function automatic logic [PW-1:0] clamp_period(input logic [PW-1:0] p);
        if (p < P_MIN) begin
            return P_MIN;
        end else if (p > P_START) begin
            return P_START;
        end
        return p;
    endfunction

endpackage

// File: rtl/step_ramp_sched_if.sv
// Command and drive bus between the tracking controller, the scheduler and the pulse generator.
interface step_ramp_sched_if;
    import step_ramp_pkg::*;

    logic          cmd_valid;
    logic [PW-1:0] cmd_period;
    logic          cmd_dir;
    logic          cmd_enable;
    logic          step_done;

    logic [PW-1:0] out_period;
    logic          out_dir;
    logic          out_enable;
    logic          at_target;
    logic          busy;

    modport master (
        output cmd_valid, cmd_period, cmd_dir, cmd_enable, step_done,
        input  out_period, out_dir, out_enable, at_target, busy
    );

    modport slave (
        input  cmd_valid, cmd_period, cmd_dir, cmd_enable, step_done,
        output out_period, out_dir, out_enable, at_target, busy
    );

endinterface

// File: rtl/step_ramp_sched_period_slew.sv
// Moves a period one slew step toward a target, never overshooting the target.
module period_slew
    import step_ramp_pkg::*;
(
    input  logic [PW-1:0] cur,
    input  logic [PW-1:0] tgt,
    output logic [PW-1:0] nxt
);

    logic [PW:0]   sum;
    logic [PW-1:0] gap;

    // One extra bit on the add so the overshoot test cannot wrap.
    always_comb begin
        sum = {1'b0, cur} + {1'b0, DELTA};
        gap = '0;
        nxt = cur;
        if (cur < tgt) begin
            nxt = (sum > {1'b0, tgt}) ? tgt : sum[PW-1:0];
        end else if (cur > tgt) begin
            gap = cur - tgt;
            nxt = (gap <= DELTA) ? tgt : (cur - DELTA);
        end
    end

endmodule

// File: rtl/step_ramp_sched.sv
// Slews the applied step period toward the commanded one and sequences stops and reversals.
module step_ramp_sched
    import step_ramp_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    step_ramp_sched_if.slave bus
);

    state_t          state, state_n;
    target_t         tgt;
    logic [PW-1:0]   out_period, period_n;
    logic            out_dir, dir_n;
    logic            out_enable, enable_n;
    logic            at_target;
    logic            busy;
    logic [DW_W-1:0] dwell_cnt, dwell_n;

    logic [PW-1:0]   slew_tgt;
    logic [PW-1:0]   slew_nxt;
    logic            must_decel;

    // Decel always heads for the start period; the ramp heads for the latched target.
    assign slew_tgt   = (state == S_DECEL) ? P_START : tgt.period;
    assign must_decel = !tgt.en || (tgt.dir != out_dir);

    period_slew u_slew (
        .cur (out_period),
        .tgt (slew_tgt),
        .nxt (slew_nxt)
    );

    always_comb begin
        state_n  = state;
        period_n = out_period;
        dir_n    = out_dir;
        enable_n = out_enable;
        dwell_n  = dwell_cnt;
        case (state)
            S_IDLE: begin
                if (tgt.en) begin
                    period_n = P_START;
                    dir_n    = tgt.dir;
                    enable_n = 1'b1;
                    state_n  = S_RAMP;
                end
            end
            S_RAMP: begin
                if (must_decel) begin
                    state_n = S_DECEL;
                end else if (bus.step_done) begin
                    period_n = slew_nxt;
                    if (slew_nxt == tgt.period) begin
                        state_n = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (must_decel) begin
                    state_n = S_DECEL;
                end else if (tgt.period != out_period) begin
                    state_n = S_RAMP;
                end
            end
            S_DECEL: begin
                if (bus.step_done) begin
                    if (out_period == P_START) begin
                        enable_n = 1'b0;
                        dwell_n  = DWELL_LAST;
                        state_n  = S_DWELL;
                    end else begin
                        period_n = slew_nxt;
                    end
                end
            end
            S_DWELL: begin
                if (dwell_cnt == '0) begin
                    state_n = S_IDLE;
                end else begin
                    dwell_n = dwell_cnt - 1'b1;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // Status flags are registered from the next-state values so they line up with the outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            tgt        <= '{period: P_START, dir: 1'b0, en: 1'b0};
            out_period <= P_START;
            out_dir    <= 1'b0;
            out_enable <= 1'b0;
            at_target  <= 1'b0;
            busy       <= 1'b0;
            dwell_cnt  <= '0;
        end else begin
            state      <= state_n;
            out_period <= period_n;
            out_dir    <= dir_n;
            out_enable <= enable_n;
            dwell_cnt  <= dwell_n;
            at_target  <= enable_n && (state_n == S_HOLD);
            busy       <= (state_n != S_IDLE);
            if (bus.cmd_valid) begin
                tgt.period <= clamp_period(bus.cmd_period);
                tgt.dir    <= bus.cmd_dir;
                tgt.en     <= bus.cmd_enable;
            end
        end
    end

    assign bus.out_period = out_period;
    assign bus.out_dir    = out_dir;
    assign bus.out_enable = out_enable;
    assign bus.at_target  = at_target;
    assign bus.busy       = busy;

endmodule

// File: tb/tb_step_ramp_sched.sv
// Directed self-checking bench for step_ramp_sched with hand-derived period sequences.
module tb_step_ramp_sched;
    import step_ramp_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    int   exp_period;
    int   n;

    step_ramp_sched_if bus ();

    step_ramp_sched dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #10 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic apply_stimulus(input int period, input logic dir, input logic en);
        bus.cmd_period = PW'(period);
        bus.cmd_dir    = dir;
        bus.cmd_enable = en;
        bus.cmd_valid  = 1'b1;
        tick();
        bus.cmd_valid  = 1'b0;
    endtask

    task automatic step_after(input int gap);
        repeat (gap - 1) tick();
        bus.step_done = 1'b1;
        tick();
        bus.step_done = 1'b0;
    endtask

    function automatic int model_step(input int cur, input int tgt);
        if (cur < tgt) return (cur + 64 > tgt) ? tgt : cur + 64;
        if (cur > tgt) return (cur - 64 < tgt) ? tgt : cur - 64;
        return cur;
    endfunction

    task automatic run_steps(input string tag, input int tgt, input int gap, input int count);
        for (int i = 0; i < count; i++) begin
            step_after(gap);
            exp_period = model_step(exp_period, tgt);
            check_output(tag, bus.out_period, exp_period);
            check_output({tag, "_range"}, (bus.out_period >= 1000 && bus.out_period <= 8333), 1);
        end
    endtask

    task automatic check_reset(input string tag);
        check_output({tag, "_period"}, bus.out_period, 8333);
        check_output({tag, "_dir"}, bus.out_dir, 0);
        check_output({tag, "_enable"}, bus.out_enable, 0);
        check_output({tag, "_at_target"}, bus.at_target, 0);
        check_output({tag, "_busy"}, bus.busy, 0);
    endtask

    initial begin
        rst            = 1'b1;
        bus.cmd_valid  = 1'b0;
        bus.cmd_period = '0;
        bus.cmd_dir    = 1'b0;
        bus.cmd_enable = 1'b0;
        bus.step_done  = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check_reset("reset");
        step_after(3);
        check_output("idle_step_ignored", bus.out_period, 8333);
        check_output("idle_busy", bus.busy, 0);

        // Start at 4000 forward, one step every 20 cycles.
        apply_stimulus(4000, 1'b1, 1'b1);
        check_output("start_latch_enable", bus.out_enable, 0);
        tick();
        check_output("start_enable", bus.out_enable, 1);
        check_output("start_dir", bus.out_dir, 1);
        check_output("start_period", bus.out_period, 8333);
        check_output("start_busy", bus.busy, 1);
        exp_period = 8333;
        for (int i = 0; i < 68; i++) begin
            step_after(20);
            exp_period = model_step(exp_period, 4000);
            check_output("ramp1_period", bus.out_period, exp_period);
            check_output("ramp1_at_target", bus.at_target, (i == 67) ? 1 : 0);
        end
        check_output("ramp1_final", bus.out_period, 4000);

        // New command lands on the same cycle as a step in HOLD.
        repeat (19) tick();
        bus.cmd_period = PW'(5000);
        bus.cmd_dir    = 1'b1;
        bus.cmd_enable = 1'b1;
        bus.cmd_valid  = 1'b1;
        bus.step_done  = 1'b1;
        tick();
        bus.cmd_valid  = 1'b0;
        bus.step_done  = 1'b0;
        check_output("simul_period", bus.out_period, 4000);
        check_output("simul_at_target", bus.at_target, 1);
        tick();
        check_output("simul_leave_hold", bus.at_target, 0);
        step_after(20);
        check_output("simul_next_step", bus.out_period, 4064);
        exp_period = 4064;
        run_steps("ramp_5000", 5000, 4, 15);
        check_output("hold_5000_at_target", bus.at_target, 1);

        // Out-of-range periods clamp.
        apply_stimulus(60000, 1'b1, 1'b1);
        run_steps("clamp_hi", 8333, 4, 53);
        check_output("clamp_hi_at_target", bus.at_target, 1);
        step_after(4);
        check_output("clamp_hi_hold", bus.out_period, 8333);
        apply_stimulus(0, 1'b1, 1'b1);
        run_steps("clamp_lo", 1000, 4, 115);
        check_output("clamp_lo_at_target", bus.at_target, 1);
        step_after(4);
        check_output("clamp_lo_hold", bus.out_period, 1000);

        // Reversal from HOLD@4000: decel, disable, dwell, restart backward.
        apply_stimulus(4000, 1'b1, 1'b1);
        run_steps("back_4000", 4000, 4, 47);
        check_output("back_4000_at_target", bus.at_target, 1);
        apply_stimulus(4000, 1'b0, 1'b1);
        tick();
        check_output("rev_at_target", bus.at_target, 0);
        check_output("rev_enable", bus.out_enable, 1);
        check_output("rev_dir_held", bus.out_dir, 1);
        run_steps("rev_decel", 8333, 20, 68);
        check_output("rev_decel_enable", bus.out_enable, 1);
        step_after(20);
        check_output("rev_disable", bus.out_enable, 0);
        check_output("rev_disable_busy", bus.busy, 1);
        check_output("rev_disable_dir", bus.out_dir, 1);
        n = 0;
        while (bus.out_enable == 1'b0 && n < 700) begin
            tick();
            n++;
        end
        check_output("rev_dwell_cycles", n, 501);
        check_output("rev_restart_dir", bus.out_dir, 0);
        check_output("rev_restart_period", bus.out_period, 8333);
        check_output("rev_restart_busy", bus.busy, 1);
        exp_period = 8333;
        run_steps("rev_ramp", 4000, 4, 68);
        check_output("rev_ramp_at_target", bus.at_target, 1);

        // Commands during DECEL and DWELL are only latched.
        apply_stimulus(4000, 1'b1, 1'b1);
        tick();
        run_steps("seq_decel_a", 8333, 4, 10);
        apply_stimulus(4000, 1'b0, 1'b1);
        run_steps("seq_decel_b", 8333, 4, 58);
        check_output("seq_dir_held", bus.out_dir, 0);
        step_after(4);
        check_output("seq_disable", bus.out_enable, 0);
        repeat (100) tick();
        apply_stimulus(4000, 1'b1, 1'b0);
        n = 0;
        while (bus.busy == 1'b1 && n < 700) begin
            tick();
            n++;
        end
        check_output("seq_reach_idle", bus.busy, 0);
        repeat (20) tick();
        check_output("seq_idle_wait_enable", bus.out_enable, 0);
        check_output("seq_idle_wait_busy", bus.busy, 0);
        apply_stimulus(4000, 1'b1, 1'b1);
        tick();
        check_output("seq_restart_enable", bus.out_enable, 1);
        check_output("seq_restart_dir", bus.out_dir, 1);

        // Reset in RAMP.
        exp_period = 8333;
        run_steps("pre_rst_ramp", 4000, 4, 3);
        check_output("pre_rst_period", bus.out_period, 8141);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset("rst_ramp");
        step_after(4);
        check_output("rst_ramp_step_ignored", bus.out_period, 8333);
        repeat (10) tick();
        check_output("rst_ramp_stay_off", bus.out_enable, 0);
        check_output("rst_ramp_idle", bus.busy, 0);

        // Reset in DWELL.
        apply_stimulus(8333, 1'b1, 1'b1);
        tick();
        check_output("dw_enable", bus.out_enable, 1);
        apply_stimulus(8333, 1'b1, 1'b0);
        tick();
        step_after(4);
        check_output("dw_disable", bus.out_enable, 0);
        repeat (10) tick();
        check_output("dw_busy", bus.busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset("rst_dwell");
        step_after(4);
        check_output("rst_dwell_step_ignored", bus.out_period, 8333);
        repeat (600) tick();
        check_output("rst_dwell_stay_off", bus.out_enable, 0);
        check_output("rst_dwell_idle", bus.busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
